// File: rtl/alsu_cmd_issuer_if.sv
// Command handshake bundle between a command producer and alsu_cmd_issuer.
//   cmd_valid   producer -> issuer  command present
//   cmd_ready   issuer -> producer  issuer can take the command this cycle
//   cmd_opcode  producer -> issuer  ALSU opcode
//   cmd_a/b     producer -> issuer  operands, BITS wide
//   cmd_ctrl    producer -> issuer  {cin,SI,sh_left,red_op_A,red_op_B,pass_A,pass_B}
interface alsu_cmd_issuer_if #(
  parameter int BITS = 3
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_opcode;
  logic [BITS-1:0] cmd_a;
  logic [BITS-1:0] cmd_b;
  logic [6:0]      cmd_ctrl;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_ctrl,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_ctrl,
    output cmd_ready
  );
endinterface

// File: rtl/alsu_cmd_issuer.sv
// Upstream command stage for the ALSU: queues commands in a FIFO, issues at
// most one per clock onto registered ALSU input ports, follows each issued
// command through the fixed ALSU latency and returns its result with a tag.
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   cmd                  command handshake (slave side)
//   flush                synchronous discard of queued and in-flight commands
//   stall                hold issue (FIFO keeps accepting)
//   A, B, opcode, cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B
//                        registered ALSU inputs; idle command (all 0) when nothing issues
//   alsu_out             ALSU result
//   res_valid/res_data/res_tag  one-cycle result strobe, captured result, command tag
//   level                FIFO occupancy
module alsu_cmd_issuer #(
  parameter int BITS         = 3,
  parameter int DEPTH        = 4,
  parameter int ALSU_LATENCY = 2,
  parameter int TAG_W        = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  alsu_cmd_issuer_if.slave         cmd,
  input  logic                     flush,
  input  logic                     stall,
  output logic [BITS-1:0]          A,
  output logic [BITS-1:0]          B,
  output logic [2:0]               opcode,
  output logic                     cin,
  output logic                     SI,
  output logic                     sh_left,
  output logic                     red_op_A,
  output logic                     red_op_B,
  output logic                     pass_A,
  output logic                     pass_B,
  input  logic [2*BITS-1:0]        alsu_out,
  output logic                     res_valid,
  output logic [2*BITS-1:0]        res_data,
  output logic [TAG_W-1:0]         res_tag,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]      op;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [6:0]      ctrl;
  } cmd_t;

  cmd_t                  mem [DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  accept_en;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [TAG_W-1:0]      tag_cnt;
  cmd_t                  head;

  // In-flight tracking: one valid/tag pair per cycle of ALSU latency plus the
  // cycle that lets alsu_out settle before it is captured.
  logic [ALSU_LATENCY:0] vld_p;
  logic [TAG_W-1:0]      tag_p [ALSU_LATENCY+1];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (PTR_W+1)'(DEPTH));
  assign empty = (level == '0);

  // accept_en keeps cmd_ready low while in reset and until the first edge after release.
  assign cmd.cmd_ready = accept_en & ~full;

  // A push coinciding with flush is dropped; pop never looks at the incoming command.
  assign push = cmd.cmd_valid & cmd.cmd_ready & ~flush;
  assign pop  = ~empty & ~stall & ~flush;
  assign head = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      accept_en <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_cnt   <= '0;
    end else begin
      accept_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) tag_cnt <= tag_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {cmd.cmd_opcode, cmd.cmd_a, cmd.cmd_b, cmd.cmd_ctrl};
  end

  // ---- issue stage: ALSU input ports (idle command whenever nothing pops) ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      opcode <= '0;
      A      <= '0;
      B      <= '0;
      {cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B} <= '0;
    end else if (pop) begin
      opcode <= head.op;
      A      <= head.a;
      B      <= head.b;
      {cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B} <= head.ctrl;
    end else begin
      opcode <= '0;
      A      <= '0;
      B      <= '0;
      {cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B} <= '0;
    end
  end

  // ---- in-flight pipe: stage 0 loads at issue, stage ALSU_LATENCY feeds retire ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else begin
      vld_p <= {vld_p[ALSU_LATENCY-1:0], pop};
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= tag_cnt;
    for (int i = 1; i <= ALSU_LATENCY; i++) tag_p[i] <= tag_p[i-1];
  end

  // ---- retire stage: capture alsu_out for the command leaving the pipe ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else begin
      res_valid <= vld_p[ALSU_LATENCY] & ~flush;
      if (vld_p[ALSU_LATENCY] && !flush) begin
        res_data <= alsu_out;
        res_tag  <= tag_p[ALSU_LATENCY];
      end
    end
  end

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Directed bench for alsu_cmd_issuer with a small two-cycle ALSU model
// (ADD returns A+B, every other opcode returns {A,B}).
module tb_alsu_cmd_issuer;
  localparam int BITS  = 3;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int TAG_W = 4;

  logic             clk   = 1'b0;
  logic             rstn  = 1'b0;
  logic             flush = 1'b0;
  logic             stall = 1'b0;
  logic [BITS-1:0]  A, B;
  logic [2:0]       opcode;
  logic             cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B;
  logic [2*BITS-1:0] alsu_out = '0;
  logic [2*BITS-1:0] alsu_p1  = '0;
  logic             res_valid;
  logic [2*BITS-1:0] res_data;
  logic [TAG_W-1:0] res_tag;
  logic [2:0]       level;
  logic [6:0]       ctrl_o;
  logic [15:0]      ports;

  alsu_cmd_issuer_if #(.BITS(BITS)) cif ();

  alsu_cmd_issuer #(
    .BITS(BITS), .DEPTH(DEPTH), .ALSU_LATENCY(LAT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd(cif), .flush(flush), .stall(stall),
    .A(A), .B(B), .opcode(opcode), .cin(cin), .SI(SI), .sh_left(sh_left),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .pass_A(pass_A), .pass_B(pass_B),
    .alsu_out(alsu_out), .res_valid(res_valid), .res_data(res_data),
    .res_tag(res_tag), .level(level)
  );

  always #5 clk = ~clk;

  assign ctrl_o = {cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B};
  assign ports  = {opcode, A, B, ctrl_o};

  // ALSU model: ports change at edge t, alsu_out changes at edge t+2.
  always @(posedge clk) begin
    alsu_p1  <= (opcode == 3'b010) ? ({3'b000, A} + {3'b000, B}) : {A, B};
    alsu_out <= alsu_p1;
  end

  // Result monitor.
  int cyc = 0;
  int rv_tag[$];
  int rv_data[$];
  int rv_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      rv_tag.push_back(int'(res_tag));
      rv_data.push_back(int'(res_data));
      rv_cyc.push_back(cyc);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [6:0] c);
    cif.cmd_opcode = op;
    cif.cmd_a      = a;
    cif.cmd_b      = b;
    cif.cmd_ctrl   = c;
  endtask

  task automatic clear_mon();
    rv_tag.delete();
    rv_data.delete();
    rv_cyc.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    cif.cmd_valid = 1'b0;
    set_cmd(3'b000, 3'd0, 3'd0, 7'd0);

    // Reset state and cmd_ready behaviour around release
    repeat (2) step();
    chk("rst_ready_low", cif.cmd_ready, 0);
    chk("rst_level", level, 0);
    rstn = 1'b1;
    step();
    chk("ready_after_release", cif.cmd_ready, 1);

    // Reset with two queued commands drops them
    stall = 1'b1;
    cif.cmd_valid = 1'b1;
    set_cmd(3'b010, 3'd1, 3'd1, 7'h7f);
    step();
    step();
    cif.cmd_valid = 1'b0;
    chk("t1_level_queued", level, 2);
    #2 rstn = 1'b0;
    #1;
    chk("t1_level_in_rst", level, 0);
    chk("t1_ports_in_rst", ports, 0);
    chk("t1_res_valid_in_rst", res_valid, 0);
    chk("t1_res_data_in_rst", res_data, 0);
    chk("t1_res_tag_in_rst", res_tag, 0);
    chk("t1_ready_in_rst", cif.cmd_ready, 0);
    step();
    rstn = 1'b1;
    stall = 1'b0;
    repeat (8) step();
    chk("t1_no_res_for_dropped", rv_tag.size(), 0);
    chk("t1_ports_idle", ports, 0);
    chk("t1_level_after", level, 0);

    // Single ADD through the pipe
    clear_mon();
    set_cmd(3'b010, 3'd3, 3'd2, 7'd0);
    cif.cmd_valid = 1'b1;
    step();
    cif.cmd_valid = 1'b0;
    chk("t2_no_bypass", ports, 0);
    chk("t2_level_1", level, 1);
    step();
    chk("t2_issue_ports", ports, {3'b010, 3'd3, 3'd2, 7'd0});
    chk("t2_level_0", level, 0);
    step();
    chk("t2_idle_after_issue", ports, 0);
    step();
    chk("t2_res_not_early", res_valid, 0);
    step();
    chk("t2_res_valid", res_valid, 1);
    chk("t2_res_tag", res_tag, 0);
    chk("t2_res_data", res_data, 5);
    step();
    chk("t2_res_one_cycle", res_valid, 0);

    // Fill under stall, then drain back-to-back
    do_reset();
    clear_mon();
    stall = 1'b1;
    cif.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(3'b010, 3'(i + 1), 3'(i), (i == 0) ? 7'b1100100 : 7'd0);
      step();
    end
    chk("t3_level_full", level, 4);
    chk("t3_ready_full", cif.cmd_ready, 0);
    set_cmd(3'b010, 3'd5, 3'd4, 7'd0);
    step();
    chk("t3_level_hold", level, 4);
    chk("t3_ready_hold", cif.cmd_ready, 0);
    stall = 1'b0;
    step();
    chk("t3_first_issue", ports, {3'b010, 3'd1, 3'd0, 7'b1100100});
    chk("t3_cin", cin, 1);
    chk("t3_pass_b", pass_B, 0);
    chk("t3_level_after_pop", level, 3);
    chk("t3_ready_after_pop", cif.cmd_ready, 1);
    step();
    cif.cmd_valid = 1'b0;
    chk("t3_level_push_pop", level, 3);
    chk("t3_second_a", A, 2);
    repeat (8) step();
    chk("t3_res_count", rv_tag.size(), 5);
    chk("t3_level_drained", level, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < rv_tag.size()) begin
        chk($sformatf("t3_tag%0d", i), rv_tag[i], i);
        chk($sformatf("t3_data%0d", i), rv_data[i], 2 * i + 1);
        if (i > 0) chk($sformatf("t3_b2b%0d", i), rv_cyc[i] - rv_cyc[i-1], 1);
      end
    end

    // Tag wrap across 17 commands
    do_reset();
    clear_mon();
    cif.cmd_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_cmd(3'b010, 3'(i % 8), 3'((3 * i) % 8), 7'd0);
      chk($sformatf("t4_ready%0d", i), cif.cmd_ready, 1);
      step();
    end
    cif.cmd_valid = 1'b0;
    repeat (6) step();
    chk("t4_res_count", rv_tag.size(), 17);
    for (int i = 0; i < 17; i++) begin
      if (i < rv_tag.size()) begin
        chk($sformatf("t4_tag%0d", i), rv_tag[i], i % 16);
        chk($sformatf("t4_data%0d", i), rv_data[i], (i % 8) + ((3 * i) % 8));
      end
    end

    // Flush with 3 queued and 2 in flight; tag counter continues at 3
    clear_mon();
    stall = 1'b1;
    cif.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(3'b001, 3'(i), 3'd0, 7'd0);
      step();
    end
    stall = 1'b0;
    set_cmd(3'b001, 3'd4, 3'd0, 7'd0);
    step();
    chk("t5_level_a", level, 3);
    step();
    chk("t5_level_b", level, 3);
    chk("t5_ports_x1", ports, {3'b001, 3'd1, 3'd0, 7'd0});
    flush = 1'b1;
    set_cmd(3'b001, 3'd5, 3'd0, 7'd0);
    step();
    flush = 1'b0;
    cif.cmd_valid = 1'b0;
    chk("t5_level_flushed", level, 0);
    chk("t5_ports_idle", ports, 0);
    repeat (6) step();
    chk("t5_no_res", rv_tag.size(), 0);
    chk("t5_level_still0", level, 0);
    set_cmd(3'b010, 3'd7, 3'd7, 7'd0);
    cif.cmd_valid = 1'b1;
    step();
    cif.cmd_valid = 1'b0;
    repeat (5) step();
    chk("t5_res_count", rv_tag.size(), 1);
    if (rv_tag.size() > 0) begin
      chk("t5_next_tag", rv_tag[0], 3);
      chk("t5_next_data", rv_data[0], 14);
    end

    // Push and pop in the same cycle at level 2
    do_reset();
    clear_mon();
    stall = 1'b1;
    cif.cmd_valid = 1'b1;
    set_cmd(3'b001, 3'd1, 3'd2, 7'd0);
    step();
    set_cmd(3'b011, 3'd3, 3'd4, 7'd0);
    step();
    chk("t6_level_2", level, 2);
    stall = 1'b0;
    set_cmd(3'b101, 3'd5, 3'd6, 7'd0);
    step();
    cif.cmd_valid = 1'b0;
    chk("t6_level_same", level, 2);
    chk("t6_ports_y0", ports, {3'b001, 3'd1, 3'd2, 7'd0});
    step();
    chk("t6_level_1", level, 1);
    chk("t6_ports_y1", ports, {3'b011, 3'd3, 3'd4, 7'd0});
    step();
    chk("t6_level_0", level, 0);
    chk("t6_ports_y2", ports, {3'b101, 3'd5, 3'd6, 7'd0});
    step();
    chk("t6_idle_last", ports, 0);
    repeat (4) step();
    chk("t6_res_count", rv_tag.size(), 3);
    if (rv_tag.size() == 3) begin
      chk("t6_tag0", rv_tag[0], 0);
      chk("t6_tag1", rv_tag[1], 1);
      chk("t6_tag2", rv_tag[2], 2);
      chk("t6_data0", rv_data[0], 10);
      chk("t6_data1", rv_data[1], 28);
      chk("t6_data2", rv_data[2], 46);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
